ddr5_cmd_issuer: RTL and testbench

DDR5_CMD_ISSUER -- requirements
Module: ddr5_cmd_issuer

---
 rtl/ddr5_cmd_issuer_pkg.sv | 40 ++++
 rtl/ddr5_timer.sv | 35 +++
 rtl/ddr5_cmd_issuer.sv | 183 ++++++++++++++++++
 tb/tb_ddr5_cmd_issuer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_cmd_issuer_pkg.sv
// Shared declarations for the DDR5 command issuer: request layout,
// command encoding, default timing constants and the timer width.
package Declarations2;

    // Mapped request from the queue side.
    typedef struct packed {
        logic [1:0]  operation;
        logic [2:0]  bank_group;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [7:0]  col_high;
        logic [1:0]  col_low;
    } mem_request_t;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD0  = 3'd3,
        CMD_RD1  = 3'd4,
        CMD_WR0  = 3'd5,
        CMD_WR1  = 3'd6,
        CMD_PRE  = 3'd7
    } cmd_t;

    localparam int DEF_TRCD   = 39;
    localparam int DEF_TCL    = 40;
    localparam int DEF_TCWL   = 38;
    localparam int DEF_TBURST = 8;
    localparam int DEF_TRAS   = 76;
    localparam int DEF_TRP    = 39;

    localparam int TMR_W = 16;

    // Operation 1 is the only write; 0 and 2 are reads, 3 is illegal.
    function automatic logic is_write(input logic [1:0] op);
        return op == 2'd1;
    endfunction

endpackage

// File: rtl/ddr5_timer.sv
// Load/decrement down-counter with a zero flag; holds at zero.
// Ports: clk_i, rst_i (sync, active high), load_i, val_i, zero_o.
module ddr5_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr5_cmd_issuer.sv
// Single-request DDR5 command sequencer: ACT0/ACT1, RD/WR pair, PRE,
// then done after tRP. Ports: clock, reset, req_valid/req/req_ready
// handshake in; cmd_valid/cmd_type/cmd_* command bus, done, op_error out.
module ddr5_cmd_issuer
    import Declarations2::*;
#(
    parameter int TRCD   = DEF_TRCD,
    parameter int TCL    = DEF_TCL,
    parameter int TCWL   = DEF_TCWL,
    parameter int TBURST = DEF_TBURST,
    parameter int TRAS   = DEF_TRAS,
    parameter int TRP    = DEF_TRP
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    input  mem_request_t req,
    output logic         req_ready,
    output logic         cmd_valid,
    output cmd_t         cmd_type,
    output logic [2:0]   cmd_bg,
    output logic [1:0]   cmd_bank,
    output logic [15:0]  cmd_row,
    output logic [9:0]   cmd_col,
    output logic         done,
    output logic         op_error
);

    typedef enum logic [3:0] {
        IDLE, ACT0, ACT1, WAIT_RCD, CAS0,
        CAS1, WAIT_DATA, PRE, WAIT_RP
    } state_t;

    // Wait states last N cycles and exit on the zero flag, so the timer
    // is loaded with N-1. Wait lengths: RCD = TRCD-2, data = lat+TBURST-2,
    // RP = TRP-1. TRAS is loaded at ACT0 so it hits zero at T0+TRAS-1.
    localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(TRCD - 3);
    localparam logic [TMR_W-1:0] RD_LD  = TMR_W'(TCL + TBURST - 3);
    localparam logic [TMR_W-1:0] WR_LD  = TMR_W'(TCWL + TBURST - 3);
    localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(TRP - 2);
    localparam logic [TMR_W-1:0] RAS_LD = TMR_W'(TRAS - 2);

    state_t       state_q, state_d;
    mem_request_t req_q, req_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         live_q;

    logic             dly_ld;
    logic [TMR_W-1:0] dly_val;
    logic             dly_zero;
    logic             tras_ld;
    logic             tras_zero;

    ddr5_timer #(.W(TMR_W)) u_dly (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (dly_ld),
        .val_i  (dly_val),
        .zero_o (dly_zero)
    );

    ddr5_timer #(.W(TMR_W)) u_tras (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (tras_ld),
        .val_i  (RAS_LD),
        .zero_o (tras_zero)
    );

    // live_q keeps req_ready low in the cycle right after a reset edge.
    assign req_ready = (state_q == IDLE) && live_q;
    assign done      = done_q;
    assign op_error  = err_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dly_ld  = 1'b0;
        dly_val = '0;
        tras_ld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d = req;
                    if (req.operation == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ACT0;
                    end
                end
            end
            ACT0: begin
                tras_ld = 1'b1;
                state_d = ACT1;
            end
            ACT1: begin
                dly_ld  = 1'b1;
                dly_val = RCD_LD;
                state_d = WAIT_RCD;
            end
            WAIT_RCD: begin
                if (dly_zero) state_d = CAS0;
            end
            CAS0: state_d = CAS1;
            CAS1: begin
                dly_ld  = 1'b1;
                dly_val = is_write(req_q.operation) ? WR_LD : RD_LD;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (dly_zero && tras_zero) state_d = PRE;
            end
            PRE: begin
                dly_ld  = 1'b1;
                dly_val = RP_LD;
                state_d = WAIT_RP;
            end
            WAIT_RP: begin
                if (dly_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_type  = CMD_NOP;
        cmd_bg    = '0;
        cmd_bank  = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        case (state_q)
            ACT0, ACT1: begin
                cmd_valid = 1'b1;
                cmd_type  = (state_q == ACT0) ? CMD_ACT0 : CMD_ACT1;
                cmd_bg    = req_q.bank_group;
                cmd_bank  = req_q.bank;
                cmd_row   = req_q.row;
            end
            CAS0, CAS1: begin
                cmd_valid = 1'b1;
                if (is_write(req_q.operation)) begin
                    cmd_type = (state_q == CAS0) ? CMD_WR0 : CMD_WR1;
                end else begin
                    cmd_type = (state_q == CAS0) ? CMD_RD0 : CMD_RD1;
                end
                cmd_bg   = req_q.bank_group;
                cmd_bank = req_q.bank;
                cmd_col  = {req_q.col_high, req_q.col_low};
            end
            PRE: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_PRE;
                cmd_bg    = req_q.bank_group;
                cmd_bank  = req_q.bank;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Bench for ddr5_cmd_issuer: default-timing and TRAS=100 instances
// checked every cycle against a schedule model, plus directed scenarios.
module tb_ddr5_cmd_issuer;
    import Declarations2::*;

    localparam int P_TRCD   = 39;
    localparam int P_TCL    = 40;
    localparam int P_TCWL   = 38;
    localparam int P_TBURST = 8;
    localparam int P_TRP    = 39;
    localparam int P_TRAS0  = 76;
    localparam int P_TRAS1  = 100;

    typedef struct packed {
        logic        rdy;
        logic        cv;
        cmd_t        ty;
        logic [2:0]  bg;
        logic [1:0]  bk;
        logic [15:0] row;
        logic [9:0]  col;
        logic        dn;
        logic        err;
    } obs_t;

    typedef struct {
        bit           v;
        int           a;
        mem_request_t r;
    } txn_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         vld0, vld1;
    mem_request_t req;

    logic rdy0, cv0, dn0, er0, rdy1, cv1, dn1, er1;
    cmd_t ty0, ty1;
    logic [2:0] bg0, bg1;
    logic [1:0] bk0, bk1;
    logic [15:0] row0, row1;
    logic [9:0] col0, col1;
    obs_t o[2];

    always #5 clock = ~clock;

    ddr5_cmd_issuer u_def (
        .clock(clock), .reset(reset), .req_valid(vld0), .req(req),
        .req_ready(rdy0), .cmd_valid(cv0), .cmd_type(ty0),
        .cmd_bg(bg0), .cmd_bank(bk0), .cmd_row(row0), .cmd_col(col0),
        .done(dn0), .op_error(er0)
    );

    ddr5_cmd_issuer #(.TRAS(P_TRAS1)) u_ras (
        .clock(clock), .reset(reset), .req_valid(vld1), .req(req),
        .req_ready(rdy1), .cmd_valid(cv1), .cmd_type(ty1),
        .cmd_bg(bg1), .cmd_bank(bk1), .cmd_row(row1), .cmd_col(col1),
        .done(dn1), .op_error(er1)
    );

    assign o[0] = {rdy0, cv0, ty0, bg0, bk0, row0, col0, dn0, er0};
    assign o[1] = {rdy1, cv1, ty1, bg1, bk1, row1, col1, dn1, er1};

    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    bit   rp = 1'b1;
    txn_t tx[2];
    int   ev[2][8];
    int   cnt[2][8];
    int   dcyc[2], dcnt[2], ecyc[2], ecnt[2];
    int   act0_q[$];
    int   a;

    task automatic chk(input string tag, input int d,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d got %0h exp %0h",
                   tag, d, n, got, exp);
        end
    endtask

    // Expected outputs in cycle c from the spec's timing arithmetic.
    function automatic obs_t predict(input int c, input txn_t t,
                                     input int tras, input bit rpv);
        obs_t e;
        int t0, cas, pre, dn;
        bit wr;
        e = '0;
        e.ty = CMD_NOP;
        e.rdy = !rpv;
        if (!t.v) return e;
        if (t.r.operation == 2'd3) begin
            e.err = (c == t.a + 1);
            return e;
        end
        wr  = (t.r.operation == 2'd1);
        t0  = t.a + 1;
        cas = t0 + P_TRCD;
        pre = cas + (wr ? P_TCWL : P_TCL) + P_TBURST;
        if (t0 + tras > pre) pre = t0 + tras;
        dn = pre + P_TRP;
        e.rdy = (c >= dn);
        e.dn  = (c == dn);
        if (c == t0 || c == t0 + 1) begin
            e.cv  = 1'b1;
            e.ty  = (c == t0) ? CMD_ACT0 : CMD_ACT1;
            e.bg  = t.r.bank_group;
            e.bk  = t.r.bank;
            e.row = t.r.row;
        end else if (c == cas || c == cas + 1) begin
            e.cv = 1'b1;
            if (wr) e.ty = (c == cas) ? CMD_WR0 : CMD_WR1;
            else    e.ty = (c == cas) ? CMD_RD0 : CMD_RD1;
            e.bg  = t.r.bank_group;
            e.bk  = t.r.bank;
            e.col = {t.r.col_high, t.r.col_low};
        end else if (c == pre) begin
            e.cv = 1'b1;
            e.ty = CMD_PRE;
            e.bg = t.r.bank_group;
            e.bk = t.r.bank;
        end
        return e;
    endfunction

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                ev[d][k]  = -1;
                cnt[d][k] = 0;
            end
            dcyc[d] = -1; dcnt[d] = 0;
            ecyc[d] = -1; ecnt[d] = 0;
        end
        act0_q.delete();
    endtask

    // Check cycle n, advance the model with this cycle's inputs, clock.
    task automatic step();
        obs_t e, g;
        bit v;
        for (int d = 0; d < 2; d++) begin
            g = o[d];
            e = predict(n, tx[d], (d == 0) ? P_TRAS0 : P_TRAS1, rp);
            chk("ready", d, 32'(g.rdy), 32'(e.rdy));
            chk("cmd_valid", d, 32'(g.cv), 32'(e.cv));
            chk("cmd_type", d, 32'(g.ty), 32'(e.ty));
            chk("cmd_bg", d, 32'(g.bg), 32'(e.bg));
            chk("cmd_bank", d, 32'(g.bk), 32'(e.bk));
            chk("cmd_row", d, 32'(g.row), 32'(e.row));
            chk("cmd_col", d, 32'(g.col), 32'(e.col));
            chk("done", d, 32'(g.dn), 32'(e.dn));
            chk("op_error", d, 32'(g.err), 32'(e.err));
            if (g.cv === 1'b1) begin
                cnt[d][int'(g.ty)]++;
                ev[d][int'(g.ty)] = n;
                if (d == 0 && g.ty == CMD_ACT0) act0_q.push_back(n);
            end
            if (g.dn === 1'b1) begin dcnt[d]++; dcyc[d] = n; end
            if (g.err === 1'b1) begin ecnt[d]++; ecyc[d] = n; end
            v = (d == 0) ? vld0 : vld1;
            if (reset) tx[d].v = 1'b0;
            else if (e.rdy && v) tx[d] = '{1'b1, n, req};
        end
        rp = reset;
        @(posedge clock);
        #1;
        n++;
    endtask

    function automatic mem_request_t rnd_req();
        mem_request_t r;
        r.operation  = 2'($urandom_range(0, 3));
        r.bank_group = 3'($urandom_range(0, 7));
        r.bank       = 2'($urandom_range(0, 3));
        r.row        = 16'($urandom_range(0, 65535));
        r.col_high   = 8'($urandom_range(0, 255));
        r.col_low    = 2'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        tx[0].v = 1'b0; tx[0].a = 0; tx[0].r = '0;
        tx[1].v = 1'b0; tx[1].a = 0; tx[1].r = '0;
        reset = 1'b1;
        vld0 = 1'b0;
        vld1 = 1'b0;
        req = '0;
        clr();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) step();

        // Default read on both instances; busy-time requests ignored.
        clr();
        req = '{operation: 2'd0, bank_group: 3'd3, bank: 2'd1,
                row: 16'h1234, col_high: 8'h0A, col_low: 2'd2};
        vld0 = 1'b1; vld1 = 1'b1;
        a = n;
        step();
        vld0 = 1'b0; vld1 = 1'b0;
        repeat (10) step();
        vld0 = 1'b1; vld1 = 1'b1;
        repeat (50) begin req = rnd_req(); step(); end
        vld0 = 1'b0; vld1 = 1'b0;
        while (n < a + 145) step();
        chk("rd_act0", 0, ev[0][CMD_ACT0] - a, 1);
        chk("rd_act1", 0, ev[0][CMD_ACT1] - a, 2);
        chk("rd_rd0", 0, ev[0][CMD_RD0] - a, 40);
        chk("rd_rd1", 0, ev[0][CMD_RD1] - a, 41);
        chk("rd_pre", 0, ev[0][CMD_PRE] - a, 88);
        chk("rd_done", 0, dcyc[0] - a, 127);
        chk("rd_nact", 0, cnt[0][CMD_ACT0], 1);
        chk("ras_pre", 1, ev[1][CMD_PRE] - a, 101);
        chk("ras_done", 1, dcyc[1] - a, 140);
        chk("ras_nact", 1, cnt[1][CMD_ACT0], 1);

        // Write on the default instance only.
        clr();
        req = '{operation: 2'd1, bank_group: 3'd5, bank: 2'd2,
                row: 16'hBEEF, col_high: 8'hC3, col_low: 2'd1};
        vld0 = 1'b1;
        a = n;
        step();
        vld0 = 1'b0;
        while (n < a + 130) step();
        chk("wr_wr0", 0, ev[0][CMD_WR0] - a, 40);
        chk("wr_wr1", 0, ev[0][CMD_WR1] - a, 41);
        chk("wr_pre", 0, ev[0][CMD_PRE] - a, 86);
        chk("wr_done", 0, dcyc[0] - a, 125);
        chk("wr_nrd", 0, cnt[0][CMD_RD0], 0);

        // Illegal operation.
        clr();
        req = '{operation: 2'd3, bank_group: 3'd1, bank: 2'd3,
                row: 16'h0F0F, col_high: 8'h11, col_low: 2'd3};
        vld0 = 1'b1; vld1 = 1'b1;
        a = n;
        step();
        vld0 = 1'b0; vld1 = 1'b0;
        repeat (6) step();
        chk("err_cyc", 0, ecyc[0] - a, 1);
        chk("err_cnt", 0, ecnt[0], 1);
        chk("err_ncv", 0, cnt[0][1] + cnt[0][2] + cnt[0][7], 0);
        chk("err_done", 0, dcnt[0], 0);

        // Back-to-back reads held valid.
        clr();
        req = '{operation: 2'd2, bank_group: 3'd6, bank: 2'd0,
                row: 16'h00A5, col_high: 8'h7E, col_low: 2'd0};
        vld0 = 1'b1;
        a = n;
        repeat (260) step();
        vld0 = 1'b0;
        repeat (140) step();
        chk("b2b_cnt", 0, act0_q.size(), 3);
        if (act0_q.size() >= 2) begin
            chk("b2b_first", 0, act0_q[0] - a, 1);
            chk("b2b_second", 0, act0_q[1] - a, 128);
        end

        // Reset in the middle of a read.
        clr();
        req = '{operation: 2'd0, bank_group: 3'd2, bank: 2'd1,
                row: 16'h5A5A, col_high: 8'h33, col_low: 2'd2};
        vld0 = 1'b1; vld1 = 1'b1;
        a = n;
        step();
        vld0 = 1'b0; vld1 = 1'b0;
        while (n < a + 50) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (150) step();
        chk("rst_npre", 0, cnt[0][CMD_PRE], 0);
        chk("rst_ndone", 0, dcnt[0], 0);
        chk("rst_npre", 1, cnt[1][CMD_PRE], 0);
        chk("rst_ndone", 1, dcnt[1], 0);

        // Random traffic with occasional resets.
        repeat (4000) begin
            vld0  = ($urandom_range(0, 2) == 0);
            vld1  = ($urandom_range(0, 2) == 0);
            req   = rnd_req();
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;
        vld0 = 1'b0; vld1 = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
